// File: rtl/uart_tx_sched.sv
// Round-robin arbiter that lends the UART TX byte interface to one of four requesters
// for a whole packet, with an optional channel header byte and a stall timeout.
module uart_tx_sched #(
   parameter int HEADER_EN = 1,
   parameter int TIMEOUT   = 255,
   parameter int TO_W      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_last,
   output logic [3:0]  req_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic [3:0]  grant,
   output logic        busy,
   output logic        timeout_err,
   input  logic        clear_err
);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t          state, state_nxt;
   logic [1:0]      ptr;
   logic [1:0]      id;
   logic [TO_W-1:0] to_cnt;

   logic            free;
   logic [2:0]      pick;
   logic            cur_valid;
   logic            cur_last;
   logic [7:0]      cur_data;
   logic            load_hdr;
   logic            accept;
   logic            to_hit;
   logic            release_own;

   // {found, index} of the first requester at or after start, wrapping mod 4
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
      logic [1:0] idx;
      rr_pick = '0;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (req[idx]) rr_pick = {1'b1, idx};
      end
   endfunction

   assign free      = !tx_valid || tx_ready;
   assign pick      = rr_pick(req_valid, ptr);
   assign cur_valid = req_valid[id];
   assign cur_last  = req_last[id];
   assign cur_data  = req_data[{id, 3'b000} +: 8];
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      load_hdr    = 1'b0;
      accept      = 1'b0;
      to_hit      = 1'b0;
      release_own = 1'b0;
      case (state)
         IDLE: begin
            if (pick[2]) state_nxt = (HEADER_EN != 0) ? HDR : DATA;
         end
         HDR: begin
            if (free) begin
               load_hdr  = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (cur_valid && free) begin
               accept = 1'b1;
               if (cur_last) begin
                  release_own = 1'b1;
                  state_nxt   = IDLE;
               end
            end else if (!cur_valid && (TIMEOUT != 0) && (to_cnt == TO_LIM)) begin
               // this idle cycle is the TIMEOUT-th one: force the owner out
               to_hit      = 1'b1;
               release_own = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = '0;
      req_ready[id] = accept;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         id          <= '0;
         grant       <= '0;
         to_cnt      <= '0;
         timeout_err <= 1'b0;
         tx_valid    <= 1'b0;
         tx_data     <= '0;
      end else begin
         if (state == IDLE && pick[2]) begin
            id    <= pick[1:0];
            grant <= 4'b0001 << pick[1:0];
         end
         if (release_own) begin
            grant <= '0;
            ptr   <= id + 2'd1;
         end

         // only requester silence counts; a tx_ready stall with data waiting does not
         if (state != DATA || accept) to_cnt <= '0;
         else if (!cur_valid)         to_cnt <= to_cnt + 1'b1;

         if (to_hit)         timeout_err <= 1'b1;
         else if (clear_err) timeout_err <= 1'b0;

         if (load_hdr) begin
            tx_data  <= 8'hA0 | {6'b0, id};
            tx_valid <= 1'b1;
         end else if (accept) begin
            tx_data  <= cur_data;
            tx_valid <= 1'b1;
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: header/timeout instance plus a header-less instance.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_last, req_ready, grant;
   logic [31:0] req_data;
   logic        tx_valid, tx_ready, busy, timeout_err, clear_err;
   logic [7:0]  tx_data;

   logic [3:0]  req_valid2, req_last2, req_ready2, grant2;
   logic [31:0] req_data2;
   logic        tx_valid2, tx_ready2, busy2, timeout_err2, clear_err2;
   logic [7:0]  tx_data2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0]  rq [4][$];
   logic [3:0]  acc;
   logic [7:0]  tx_log[$];
   logic [7:0]  gnt_log[$];
   logic [3:0]  prev_grant;
   logic        nx_tx_ready, nx_clear_err;
   logic [3:0]  nx2_valid, nx2_last;
   logic [31:0] nx2_data;
   int          k;

   always #5 clk = ~clk;

   uart_tx_sched #(.HEADER_EN(1), .TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant), .busy(busy),
      .timeout_err(timeout_err), .clear_err(clear_err)
   );

   uart_tx_sched #(.HEADER_EN(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_data(req_data2),
      .req_last(req_last2), .req_ready(req_ready2), .tx_valid(tx_valid2),
      .tx_data(tx_data2), .tx_ready(tx_ready2), .grant(grant2), .busy(busy2),
      .timeout_err(timeout_err2), .clear_err(clear_err2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_q(input string tag, input logic [7:0] q[$], input int n, input logic [79:0] exp);
      chk({tag, "_len"}, q.size(), n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_%0d", tag, i), (i < q.size()) ? 32'(q[i]) : 32'hDEAD,
             32'(exp[8*(n-1-i) +: 8]));
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]        = (rq[i].size() != 0);
         req_data[8*i +: 8]  = (rq[i].size() != 0) ? rq[i][0][7:0] : 8'h00;
         req_last[i]         = (rq[i].size() != 0) ? rq[i][0][8] : 1'b0;
      end
   endtask

   // one clock: retire accepted bytes, apply next inputs, then sample at the falling edge
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      drive();
      tx_ready   = nx_tx_ready;
      clear_err  = nx_clear_err;
      req_valid2 = nx2_valid;
      req_data2  = nx2_data;
      req_last2  = nx2_last;
      @(negedge clk);
      acc = req_ready;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (grant != 4'd0 && prev_grant == 4'd0) gnt_log.push_back({4'b0, grant});
      prev_grant = grant;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while ((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() != 0 || busy || tx_valid)
             && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_done"}, 32'(n < budget), 1);
   endtask

   task automatic clear_logs();
      tx_log.delete();
      gnt_log.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;
      tx_ready = 1'b1; clear_err = 1'b0;
      req_valid2 = '0; req_data2 = '0; req_last2 = '0;
      tx_ready2 = 1'b1; clear_err2 = 1'b0;
      nx_tx_ready = 1'b1; nx_clear_err = 1'b0;
      nx2_valid = '0; nx2_data = '0; nx2_last = '0;
      acc = '0; prev_grant = '0;

      // reset values
      cycle(); cycle();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(timeout_err), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_tx_valid2", 32'(tx_valid2), 0);
      rst_n = 1'b1;

      // single packet from requester 2, header enabled
      clear_logs();
      rq[2].push_back({1'b0, 8'h11});
      rq[2].push_back({1'b1, 8'h22});
      cycle();
      chk("t1_idle_busy", 32'(busy), 0);
      cycle();
      chk("t1_grant", 32'(grant), 'h4);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_no_tx_yet", 32'(tx_valid), 0);
      cycle();
      chk("t1_hdr_valid", 32'(tx_valid), 1);
      chk("t1_hdr_data", 32'(tx_data), 'hA2);
      chk("t1_ready", 32'(req_ready), 'h4);
      cycle();
      chk("t1_b0", 32'(tx_data), 'h11);
      cycle();
      chk("t1_b1", 32'(tx_data), 'h22);
      chk("t1_grant_clr", 32'(grant), 0);
      chk("t1_busy_clr", 32'(busy), 0);
      cycle();
      chk("t1_drain", 32'(tx_valid), 0);
      chk_q("t1_tx", tx_log, 3, 80'hA2_11_22);

      // pointer now 3: requester 3 wins over requester 0
      clear_logs();
      rq[0].push_back({1'b1, 8'h50});
      rq[3].push_back({1'b1, 8'h53});
      wait_done("t2", 30);
      chk_q("t2_tx", tx_log, 4, 80'hA3_53_A0_50);
      chk_q("t2_gnt", gnt_log, 2, 80'h08_01);

      // backpressure: tx_ready low for 5 cycles mid-packet
      clear_logs();
      rq[0].push_back({1'b0, 8'h31});
      rq[0].push_back({1'b0, 8'h32});
      rq[0].push_back({1'b1, 8'h33});
      k = 0;
      while (!(tx_valid && tx_data == 8'h31) && k < 20) begin
         cycle();
         k++;
      end
      chk("t3_reach", 32'(k < 20), 1);
      nx_tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk($sformatf("t3_hold_data_%0d", i), 32'(tx_data), 'h32);
         chk($sformatf("t3_hold_valid_%0d", i), 32'(tx_valid), 1);
         chk($sformatf("t3_hold_ready_%0d", i), 32'(req_ready), 0);
      end
      nx_tx_ready = 1'b1;
      wait_done("t3", 30);
      chk_q("t3_tx", tx_log, 4, 80'hA0_31_32_33);
      chk("t3_err", 32'(timeout_err), 0);

      // timeout: requester 1 stops mid-packet, pointer 1 -> next owner is 2
      clear_logs();
      rq[1].push_back({1'b0, 8'h61});
      cycle();
      chk("t4_idle", 32'(busy), 0);
      cycle();
      chk("t4_grant", 32'(grant), 'h2);
      cycle();
      chk("t4_hdr", 32'(tx_data), 'hA1);
      cycle();
      chk("t4_byte", 32'(tx_data), 'h61);
      rq[2].push_back({1'b1, 8'h62});
      rq[0].push_back({1'b1, 8'h60});
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk($sformatf("t4_held_%0d", i), 32'(grant), 'h2);
         chk($sformatf("t4_noerr_%0d", i), 32'(timeout_err), 0);
      end
      cycle();
      chk("t4_release", 32'(grant), 0);
      chk("t4_err_set", 32'(timeout_err), 1);
      chk("t4_idle_after", 32'(busy), 0);
      cycle();
      chk("t4_next_grant", 32'(grant), 'h4);
      wait_done("t4", 30);
      chk_q("t4_tx", tx_log, 6, 80'hA1_61_A2_62_A0_60);
      chk("t4_sticky", 32'(timeout_err), 1);
      nx_clear_err = 1'b1;
      cycle();
      nx_clear_err = 1'b0;
      cycle();
      chk("t4_cleared", 32'(timeout_err), 0);

      // set and clear in the same cycle: set wins
      rq[1].push_back({1'b0, 8'h63});
      for (int i = 0; i < 6; i++) cycle();
      chk("t5_pre_grant", 32'(grant), 'h2);
      nx_clear_err = 1'b1;
      cycle();
      chk("t5_pre_err", 32'(timeout_err), 0);
      nx_clear_err = 1'b0;
      cycle();
      chk("t5_err_wins", 32'(timeout_err), 1);
      chk("t5_release", 32'(grant), 0);
      wait_done("t5", 20);

      // reset mid-packet while a byte sits in the output register
      clear_logs();
      rq[3].push_back({1'b0, 8'h71});
      rq[3].push_back({1'b0, 8'h72});
      rq[3].push_back({1'b1, 8'h73});
      k = 0;
      while (!(tx_valid && tx_data == 8'h71 && busy) && k < 20) begin
         cycle();
         k++;
      end
      chk("t6_reach", 32'(k < 20), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_grant", 32'(grant), 0);
      chk("t6_tx_valid", 32'(tx_valid), 0);
      chk("t6_tx_data", 32'(tx_data), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_err", 32'(timeout_err), 0);
      chk("t6_ready", 32'(req_ready), 0);
      for (int i = 0; i < 4; i++) rq[i].delete();
      acc = '0;
      cycle();
      rst_n = 1'b1;

      // fairness after reset: order 0,1,2,3,0
      clear_logs();
      rq[0].push_back({1'b1, 8'h40});
      rq[0].push_back({1'b1, 8'h40});
      rq[1].push_back({1'b1, 8'h41});
      rq[2].push_back({1'b1, 8'h42});
      rq[3].push_back({1'b1, 8'h43});
      wait_done("t7", 60);
      chk_q("t7_tx", tx_log, 10, 80'hA0_40_A1_41_A2_42_A3_43_A0_40);
      chk_q("t7_gnt", gnt_log, 5, 80'h01_02_04_08_01);

      // header-less instance: requester 3 sends 0x5A
      nx2_valid = 4'b1000;
      nx2_data  = 32'h5A00_0000;
      nx2_last  = 4'b1000;
      cycle();
      chk("t8_c1_valid", 32'(tx_valid2), 0);
      chk("t8_c1_grant", 32'(grant2), 0);
      cycle();
      chk("t8_c2_grant", 32'(grant2), 'h8);
      chk("t8_c2_ready", 32'(req_ready2), 'h8);
      chk("t8_c2_valid", 32'(tx_valid2), 0);
      nx2_valid = '0;
      nx2_last  = '0;
      cycle();
      chk("t8_c3_valid", 32'(tx_valid2), 1);
      chk("t8_c3_data", 32'(tx_data2), 'h5A);
      chk("t8_c3_grant", 32'(grant2), 0);
      cycle();
      chk("t8_c4_valid", 32'(tx_valid2), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single UART transmit byte engine among four on-chip byte requesters. It grants one requester at a time and holds the grant for a whole packet, terminated by a `last` byte. It optionally prefixes each packet with a channel header byte and releases a stalled requester after a timeout. It sits between the requester logic and the UART TX core's byte-level valid/ready input inside `tt_um_example`.

## Interface
- `HEADER_EN`, default 1: 1 inserts header byte `8'hA0 | id` before each packet; 0 sends payload only.
- `TIMEOUT`, default 255: idle cycles allowed mid-packet before forced release; 0 disables the timeout.
- `TO_W`, default 8: timeout counter width; must satisfy `TIMEOUT < 2**TO_W`.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 4: requester i presents a byte.
- `req_data` in 32: byte of requester i on bits `[8i+7:8i]`.
- `req_last` in 4: presented byte is the final byte of the packet.
- `req_ready` out 4: byte of requester i is accepted this cycle.
- `tx_valid` out 1: byte available to the UART TX core; registered.
- `tx_data` out 8: byte to transmit; registered.
- `tx_ready` in 1: UART TX core takes the byte.
- `grant` out 4: one-hot current owner, or 0; registered.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: sticky flag, set when a forced release occurs.
- `clear_err` in 1: clears `timeout_err`.

## Operation
- States are IDLE, HDR and DATA. The block keeps a 2-bit round-robin pointer `ptr` and an owner id `id`.
- **IDLE:** if any `req_valid` bit is set, pick the first set index searching `ptr, ptr+1, …` mod 4.
  - Set `grant` and `id` to that index.
  - Go to HDR if `HEADER_EN`, otherwise go to DATA.
  - `req_valid` with no grant has no effect.
- **Output register is free** when `!tx_valid || tx_ready`.
- **HDR:** when the output register is free, load `tx_data = 8'hA0 | id`, set `tx_valid = 1`, and go to DATA. If it is not free, wait.
- **DATA:** `req_ready[id] = req_valid[id] && free`, combinational. All other `req_ready` bits are 0.
  - On accept, load `req_data[id]` into `tx_data` and set `tx_valid`.
  - If the accepted byte has `req_last[id]` set, go to IDLE, clear `grant`, and set `ptr = id + 1` mod 4.
- **Leaving the output register:** when `tx_valid && tx_ready` and nothing new is loaded, `tx_valid` drops to 0. `tx_data` is held stable while `tx_valid && !tx_ready`.
- **Timeout counter:** active in DATA only.
  - Increments on cycles where `!req_valid[id]`.
  - Clears on accept and on entry to DATA.
  - Cycles stalled only by `!tx_ready` do not count.
  - When the counter reaches `TIMEOUT` (and `TIMEOUT != 0`): go to IDLE, clear `grant`, set `ptr = id + 1`, set `timeout_err`. A byte already in the output register still drains.
- **`timeout_err`:** cleared by `clear_err`. If a set and a clear occur in the same cycle, set wins.
- **Packet atomicity:** no byte from another requester is interleaved inside a granted packet. The header is never sent without a following DATA state.
- **Reset, asynchronous:** state IDLE, `ptr = 0`, `grant = 0`, `tx_valid = 0`, `tx_data = 0`, `busy = 0`, `timeout_err = 0`, counter 0.
  - A byte pending in the output register at reset is dropped.
  - `req_ready` is 0 during reset.

## Timing
- **Arbitration latency, header enabled:** `req_valid` seen in IDLE at cycle n gives `grant` and `busy` at n+1, HDR at n+1, and header `tx_valid` at n+2 (if the register is free).
  - First `req_ready` is in cycle n+2 if `tx_ready` is high, which gives payload `tx_valid` at n+3.
- **Arbitration latency, `HEADER_EN = 0`:** DATA at n+1, `req_ready` can be high at n+1, first payload `tx_valid` at n+2.
- **Throughput:** one byte per cycle while `tx_ready` stays high. `req_ready` depends combinationally on `tx_ready`.
- **Between packets:** at least one IDLE cycle. A `last` accept at cycle k gives IDLE at k+1 and the next grant at k+2.
- **Timeout:** the release happens `TIMEOUT` consecutive cycles after the last accept or DATA entry with `req_valid[id]` low. `timeout_err` is visible the following cycle.

## Test plan
- **Single packet, `HEADER_EN = 1`:** requester 2 sends 0x11, 0x22 (last), `tx_ready` held high.
  - Required: `tx_data` sequence 0xA2, 0x11, 0x22, then `grant` = 0 and `ptr` = 3.
- **Round-robin fairness:** all four requesters hold single-byte packets, each byte `0x40 + i` with `last` set.
  - Required: grant order 0, 1, 2, 3, 0, and headers 0xA0 to 0xA3 in that order.
- **Backpressure:** drop `tx_ready` for 5 cycles mid-packet.
  - Required: `tx_data` stable, `req_ready` = 0, no byte lost or duplicated, and `timeout_err` stays 0.
- **Timeout:** `TIMEOUT = 4`; requester 1 sends one byte without `last`, then drops `req_valid`.
  - Required: release after 4 idle cycles, `timeout_err` = 1, and the next grant goes to requester 2 if it is requesting.
  - Then `clear_err` pulse: `timeout_err` = 0. A simultaneous new timeout keeps it at 1.
- **Reset mid-packet:** assert `rst_n` = 0 while `tx_valid` = 1 in DATA.
  - Required: all outputs 0 immediately, and after release the next grant starts at requester 0.
- **`HEADER_EN = 0`:** requester 3 sends 0x5A (last).
  - Required: `tx_valid` with 0x5A two cycles after `req_valid`, and no header byte.
